// File: rtl/d7seg_pkg.sv
// d7seg_pkg: shared constants and helpers for the multiplexed 7-segment scan driver.
//   N_DIG_DEF / DIV_MAX_DEF : default digit count and prescaler terminal count
//   N_DIG_MAX               : widest supported display (helpers are sized for it)
//   AN_OFF                  : all anodes disabled (active-low), slice to N_DIG bits
//   lz_mask()               : per-digit leading-zero blank mask
package d7seg_pkg;

   localparam int unsigned N_DIG_DEF   = 4;
   localparam int unsigned DIV_MAX_DEF = 49999;
   localparam int unsigned N_DIG_MAX   = 8;

   localparam logic [N_DIG_MAX-1:0] AN_OFF = '1;

   // Bit i set when digit i and every digit above it (up to n_dig-1) is zero.
   // Digit 0 is never flagged so an all-zero value still shows one "0".
   function automatic logic [N_DIG_MAX-1:0] lz_mask(input logic [4*N_DIG_MAX-1:0] val,
                                                    input int unsigned            n_dig);
      logic                 zero_run;
      logic [N_DIG_MAX-1:0] mask;
      zero_run = 1'b1;
      mask     = '0;
      for (int unsigned i = N_DIG_MAX - 1; i > 0; i--) begin
         if (i < n_dig) begin
            zero_run = zero_run & (4'(val >> (4 * i)) == 4'h0);
            mask[i]  = zero_run;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/d7seg_tick.sv
// d7seg_tick: refresh prescaler for the scan driver.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; the counter holds while low
//   step     : high in the enabled cycle the count reaches DIV_MAX
module d7seg_tick #(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DIV_MAX = 49999
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic step
);

   logic [DIV_W-1:0] count;

   // Terminal-count decode; DIV_MAX=0 yields a step every enabled cycle.
   always_comb begin
      step = en && (count == DIV_W'(DIV_MAX));
   end

   // Counter wraps to zero in the same cycle it signals a step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (step) count <= '0;
         else      count <= count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/d7seg_scan.sv
// d7seg_scan: time-multiplexed scan driver feeding a hex-to-7-segment decoder.
//   clk, rst : clock, asynchronous active-high reset
//   en       : scan enable (0 = dark, scan frozen)
//   load     : strobe capturing value / dp_in (double-buffered, applied at frame wrap)
//   value    : N_DIG hex digits, digit 0 in the low nibble
//   dp_in    : per-digit decimal point request, 1 = lit
//   blank_lz : blank leading zero digits
//   dig      : nibble of the active digit
//   an       : active-low anode enables, at most one low
//   dp       : active-low decimal point
//   frame    : one-cycle pulse after the scan wraps back to digit 0
module d7seg_scan
   import d7seg_pkg::*;
#(
   parameter int unsigned N_DIG   = N_DIG_DEF,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DIV_MAX = DIV_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               load,
   input  logic [4*N_DIG-1:0] value,
   input  logic [N_DIG-1:0]   dp_in,
   input  logic               blank_lz,
   output logic [3:0]         dig,
   output logic [N_DIG-1:0]   an,
   output logic               dp,
   output logic               frame
);

   localparam int unsigned VAL_W = 4 * N_DIG;
   localparam int unsigned IDX_W = $clog2(N_DIG);
   localparam logic [N_DIG-1:0] AN_ONE = N_DIG'(1);

   logic                 step;
   logic                 wrap;
   logic [IDX_W-1:0]     idx;
   logic [VAL_W-1:0]     shadow_val;
   logic [N_DIG-1:0]     shadow_dp;
   logic [VAL_W-1:0]     pend_val;
   logic [N_DIG-1:0]     pend_dp;
   logic                 pend_flag;

   logic [N_DIG_MAX-1:0] blank_mask_c;
   logic                 blank_c;
   logic [3:0]           dig_c;
   logic [N_DIG-1:0]     an_c;
   logic                 dp_c;

   d7seg_tick #(
      .DIV_W   (DIV_W),
      .DIV_MAX (DIV_MAX)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .step (step)
   );

   always_comb begin
      wrap = step && (idx == IDX_W'(N_DIG - 1));
   end

   // Digit index advances on each prescaler step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (step) begin
         if (wrap) idx <= '0;
         else      idx <= idx + IDX_W'(1);
      end
   end

   // Double buffer: loads park in pending and move to shadow only at a frame
   // boundary, except when the display is dark or the load lands on the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_flag  <= 1'b0;
      end else if (load && (!en || wrap)) begin
         shadow_val <= value;
         shadow_dp  <= dp_in;
         pend_flag  <= 1'b0;
      end else if (load) begin
         pend_val   <= value;
         pend_dp    <= dp_in;
         pend_flag  <= 1'b1;
      end else if (wrap && pend_flag) begin
         shadow_val <= pend_val;
         shadow_dp  <= pend_dp;
         pend_flag  <= 1'b0;
      end
   end

   // Output decode for the current digit; blanking acts on an/dp only.
   always_comb begin
      blank_mask_c = lz_mask((4 * N_DIG_MAX)'(shadow_val), N_DIG) & {N_DIG_MAX{blank_lz}};
      blank_c      = blank_mask_c[3'(idx)];
      dig_c        = shadow_val[{idx, 2'b00} +: 4];
      dp_c         = blank_c | ~shadow_dp[idx];
      an_c         = (!en || blank_c) ? AN_OFF[N_DIG-1:0] : ~(AN_ONE << idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig   <= 4'h0;
         an    <= AN_OFF[N_DIG-1:0];
         dp    <= 1'b1;
         frame <= 1'b0;
      end else begin
         dig   <= dig_c;
         an    <= an_c;
         dp    <= dp_c;
         frame <= wrap;
      end
   end

endmodule

// File: tb/tb_d7seg_scan.sv
// tb_d7seg_scan: directed + random checks of d7seg_scan (N_DIG=4, DIV_MAX=3)
// against a behavioural model of the display rules.
module tb_d7seg_scan;

   localparam int unsigned N  = 4;
   localparam int unsigned DM = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  dig;
   logic [3:0]  an;
   logic        dp;
   logic        frame;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_cnt;
   int          m_idx;
   logic [15:0] m_sh;
   logic [3:0]  m_shdp;
   logic [15:0] m_pend;
   logic [3:0]  m_penddp;
   bit          m_pf;
   logic [3:0]  e_dig;
   logic [3:0]  e_an;
   logic        e_dp;
   logic        e_frame;

   d7seg_scan #(.N_DIG(N), .DIV_W(16), .DIV_MAX(DM)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .value    (value),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .dig      (dig),
      .an       (an),
      .dp       (dp),
      .frame    (frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 0; m_sh = '0; m_shdp = '0; m_pend = '0; m_penddp = '0; m_pf = 0;
      e_dig = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
   endtask

   // One clock edge of the display rules, using the inputs present before the edge.
   task automatic model_edge();
      bit          stp, wrp, blanked;
      logic [15:0] upper;
      if (rst) begin
         model_reset();
         return;
      end
      stp     = en && (m_cnt == int'(DM));
      wrp     = stp && (m_idx == int'(N) - 1);
      upper   = m_sh >> (4 * m_idx);
      blanked = blank_lz && (m_idx > 0) && (upper == 16'h0);
      e_dig   = upper[3:0];
      e_an    = (!en || blanked) ? 4'hF : ~(4'b0001 << m_idx);
      e_dp    = blanked ? 1'b1 : ~m_shdp[m_idx];
      e_frame = wrp;
      if (en) begin
         m_cnt = stp ? 0 : m_cnt + 1;
         if (stp) m_idx = (m_idx + 1) % int'(N);
      end
      if (load && (!en || wrp)) begin
         m_sh = value; m_shdp = dp_in; m_pf = 0;
      end else if (load) begin
         m_pend = value; m_penddp = dp_in; m_pf = 1;
      end else if (wrp && m_pf) begin
         m_sh = m_pend; m_shdp = m_penddp; m_pf = 0;
      end
   endtask

   task automatic check_outs();
      chk("dig", 32'(dig), 32'(e_dig));
      chk("an", 32'(an), 32'(e_an));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame", 32'(frame), 32'(e_frame));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
      value = v; dp_in = d; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic wait_idx(input int target);
      int n = 0;
      while (m_idx != target && n < 200) begin cyc(); n++; end
      chk("wait_idx", 32'(n < 200), 32'd1);
   endtask

   task automatic wait_frame();
      int n = 0;
      while (frame !== 1'b1 && n < 200) begin cyc(); n++; end
      chk("wait_frame", 32'(n < 200), 32'd1);
   endtask

   task automatic wait_pre_wrap();
      int n = 0;
      while (!(en && m_cnt == int'(DM) && m_idx == int'(N) - 1) && n < 200) begin cyc(); n++; end
      chk("wait_pre_wrap", 32'(n < 200), 32'd1);
   endtask

   initial begin
      int frames, lit_hi, lit1, lit0;
      rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_dp", 32'(dp), 32'd1);
      chk("reset_dig", 32'(dig), 32'd0);
      chk("reset_frame", 32'(frame), 32'd0);
      rst = 1'b0;

      // Reset scan: immediate load while dark, then one full frame.
      load_pulse(16'h1A2F, 4'b0000);
      en = 1'b1;
      cyc();
      frames = 0;
      repeat (16) begin
         cyc();
         if (frame) frames++;
         case (an)
            4'b1110: chk("scan_d0", 32'(dig), 32'hF);
            4'b1101: chk("scan_d1", 32'(dig), 32'h2);
            4'b1011: chk("scan_d2", 32'(dig), 32'hA);
            4'b0111: chk("scan_d3", 32'(dig), 32'h1);
            default: chk("scan_an_onehot", 32'(an), 32'hE);
         endcase
      end
      chk("frames_per_16", 32'(frames), 32'd1);

      // Tear-free update: load mid-frame, takes effect at the next frame.
      wait_idx(1);
      load_pulse(16'h0000, 4'b0000);
      repeat (24) cyc();

      // Leading-zero blanking.
      blank_lz = 1'b1;
      load_pulse(16'h0040, 4'b0000);
      wait_frame();
      lit_hi = 0; lit1 = 0;
      repeat (16) begin
         cyc();
         if (an == 4'b0111 || an == 4'b1011) lit_hi++;
         if (an == 4'b1101) begin lit1++; chk("lz_d1", 32'(dig), 32'h4); end
         if (an == 4'b1110) chk("lz_d0", 32'(dig), 32'h0);
      end
      chk("lz_hi_dark", 32'(lit_hi), 32'd0);
      chk("lz_d1_lit", 32'(lit1), 32'd4);

      load_pulse(16'h0000, 4'b0000);
      wait_frame();
      lit0 = 0; lit_hi = 0;
      repeat (16) begin
         cyc();
         if (an == 4'b1110) begin lit0++; chk("zero_d0", 32'(dig), 32'h0); end
         else if (an != 4'hF) lit_hi++;
      end
      chk("zero_only_d0", 32'(lit0), 32'd4);
      chk("zero_others_dark", 32'(lit_hi), 32'd0);

      // Decimal point, lit and then suppressed on a blanked digit.
      blank_lz = 1'b0;
      load_pulse(16'h1234, 4'b0100);
      wait_frame();
      repeat (16) begin
         cyc();
         chk("dp_vs_an", 32'(dp), (an == 4'b1011) ? 32'd0 : 32'd1);
      end
      blank_lz = 1'b1;
      load_pulse(16'h0034, 4'b0100);
      wait_frame();
      repeat (16) begin
         cyc();
         chk("dp_blanked", 32'(dp), 32'd1);
      end

      // Enable drop mid-frame, immediate load while dark, resume.
      blank_lz = 1'b0;
      wait_idx(2);
      en = 1'b0;
      cyc();
      chk("en_off_an", 32'(an), 32'hF);
      repeat (5) cyc();
      load_pulse(16'h5678, 4'b0001);
      repeat (3) cyc();
      en = 1'b1;
      repeat (20) cyc();

      // Load coincident with wrap shows from digit 0 straight away.
      wait_pre_wrap();
      load_pulse(16'hBEEF, 4'b0000);
      chk("coinc_frame", 32'(frame), 32'd1);
      cyc();
      chk("coinc_an", 32'(an), 32'hE);
      chk("coinc_dig", 32'(dig), 32'hF);
      repeat (10) cyc();

      // Asynchronous reset between edges.
      #2;
      rst = 1'b1;
      #1;
      chk("arst_an", 32'(an), 32'hF);
      chk("arst_dp", 32'(dp), 32'd1);
      chk("arst_dig", 32'(dig), 32'd0);
      model_reset();
      cyc();
      cyc();
      #2;
      rst = 1'b0;
      repeat (20) cyc();

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         en       = ($urandom_range(0, 9) != 0);
         blank_lz = ($urandom_range(0, 3) != 0);
         value    = 16'($urandom >> (4 * $urandom_range(0, 4)));
         dp_in    = 4'($urandom);
         load     = ($urandom_range(0, 7) == 0);
         cyc();
      end
      load = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
